uart_boot_loader: RTL and testbench
===================================

// Module: uart_boot_loader
// PURPOSE
//   Upstream of the single-cycle core: receives a program over a UART line and writes it word-by-word
//   into the instruction memory write port, holding the core in reset until the image is complete.
//   Instruction memory is word-addressed (PC[7:2]) and 64 words deep; this block drives that port.
//   Image format: 1 count byte N (words), then 4*N payload bytes, each word LSB first.
// PARAMETERS
//   CLKS_PER_BIT  868  clk cycles per UART bit (100 MHz / 115200); must be >= 4
//   ADDR_W        6    instruction memory word-address width; max image = 2**ADDR_W words
// PORTS
//   clk          in   1       system clock, all logic on posedge
//   reset        in   1       asynchronous, active-high; clears all state
//   boot_en      in   1       sampled in IDLE; 1 = load image, 0 = release core immediately
//   rx           in   1       UART serial input, idle high, 8N1
//   imem_we      out  1       one-cycle instruction memory write strobe
//   imem_addr    out  ADDR_W  word address of current write
//   imem_wdata   out  32      assembled instruction word
//   cpu_hold     out  1       1 = keep core in reset (wire to core reset OR'ed with reset)
//   load_done    out  1       1 = image written and core released
//   load_err     out  1       sticky error flag (framing, oversize count, checksum)
// BEHAVIOUR
//   Reset values: imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, load_done=0, load_err=0; FSM=IDLE.
//   UART RX: rx passes a 2-flop synchronizer (2-cycle latency). Falling edge starts a bit counter;
//   resample at CLKS_PER_BIT/2: if high -> false start, ignore. Data bits sampled mid-bit, LSB first,
//   every CLKS_PER_BIT. Stop bit sampled mid-bit: 1 -> internal byte_valid pulses 1 cycle;
//   0 -> framing error (byte discarded, load_err=1, FSM -> GET_COUNT, imem_addr=0).
//   FSM states: IDLE, GET_COUNT, GET_DATA, WRITE, CHECK (macro only), DONE.
//   IDLE: first cycle after reset; boot_en=0 -> DONE; boot_en=1 -> GET_COUNT.
//   GET_COUNT: on byte_valid latch N. N=0 -> DONE. N>2**ADDR_W -> load_err=1, stay GET_COUNT.
//     Else clear byte index and word counter, imem_addr=0, -> GET_DATA.
//   GET_DATA: byte k (0..3) shifted into imem_wdata[8k+7:8k]; on 4th byte -> WRITE.
//   WRITE: imem_we=1 for exactly this one cycle with stable addr/data; next cycle imem_addr+1
//     (wraps to 0 only after final word, never written), words_left-1; words_left 0 -> DONE
//     (or CHECK with macro), else GET_DATA.
//   DONE: cpu_hold=0 and load_done=1 from the first cycle in DONE; terminal until reset.
//     UART bytes received in DONE are ignored. load_err keeps its value (not cleared).
//   load_err clears only on reset or on entry to DONE via a successful load (boot_en=1 path).
//   Write latency: imem_we asserts 1 cycle after byte_valid of a word's 4th byte.
//   Reset mid-load: everything returns to reset values; partially written memory is not cleared.
//   boot_en changes outside IDLE are ignored.
// CONFIGURATION
//   BOOT_CHECKSUM_EN defined: after the last payload byte FSM enters CHECK and waits one more byte;
//     it must equal XOR of all 4*N payload bytes (count byte excluded). Match -> DONE;
//     mismatch -> load_err=1, imem_addr=0, -> GET_COUNT (core stays held, reload required).
//   Not defined: no CHECK state, no XOR register; WRITE of last word goes directly to DONE.
// TESTING  (CLKS_PER_BIT=4 in simulation)
//   reset then boot_en=0 -> cpu_hold=0, load_done=1 on 2nd cycle after reset release; imem_we never 1.
//   boot_en=1, send 02, 13 05 50 00, 93 05 10 00 -> imem_we pulses: addr 0 data 0x00500513,
//     addr 1 data 0x00100593; then cpu_hold=0, load_done=1, load_err=0.
//   Count byte 0x41 (65 > 64) -> load_err=1, cpu_hold=1, no writes; then 01,6F 00 00 00 -> addr 0
//     data 0x0000006F written, load_done=1, load_err=0.
//   Stop bit forced 0 on 3rd payload byte -> load_err=1, FSM back to GET_COUNT, imem_addr=0, cpu_hold=1.
//   rx low pulse of 1 clk (glitch) while idle -> no byte accepted, no state change.
//   BOOT_CHECKSUM_EN: 01, 13 00 00 00, 13 -> load_done=1; same with checksum 0x12 -> load_err=1, cpu_hold=1.

Source files
------------

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a word image (count byte, then LSB-first words) and writes it into instruction memory.
// Optional macro BOOT_CHECKSUM_EN adds a trailing XOR checksum byte and a CHECK state.
module uart_boot_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              boot_en,
    input  logic              rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam int CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int MAX_WORDS = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        IDLE,
        GET_COUNT,
        GET_DATA,
        WRITE,
`ifdef BOOT_CHECKSUM_EN
        CHECK,
`endif
        DONE
    } state_t;

    logic             rx_meta_r;
    logic             rx_sync_r;
    rx_state_t        rx_state_r;
    logic [CNT_W-1:0] rx_cnt_r;
    logic [2:0]       rx_bit_r;
    logic [7:0]       rx_shift_r;
    logic             byte_valid_r;
    logic             frame_err_r;

    state_t           state_r;
    logic [1:0]       byte_idx_r;
    logic [7:0]       words_left_r;
    logic             count_too_big_s;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]       csum_r;
`endif

    assign count_too_big_s = ({24'd0, rx_shift_r} > 32'(MAX_WORDS));

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // 8N1 receiver: start bit re-checked at half a bit, data and stop sampled mid-bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_r   <= RX_IDLE;
            rx_cnt_r     <= {CNT_W{1'b0}};
            rx_bit_r     <= 3'd0;
            rx_shift_r   <= 8'h00;
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    rx_cnt_r <= {CNT_W{1'b0}};
                    if (!rx_sync_r) rx_state_r <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt_r == HALF_LAST) begin
                        rx_cnt_r   <= {CNT_W{1'b0}};
                        rx_bit_r   <= 3'd0;
                        rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_r == BIT_LAST) begin
                        rx_cnt_r   <= {CNT_W{1'b0}};
                        rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                        rx_bit_r   <= rx_bit_r + 3'd1;
                        if (rx_bit_r == 3'd7) rx_state_r <= RX_STOP;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_r == BIT_LAST) begin
                        rx_cnt_r   <= {CNT_W{1'b0}};
                        rx_state_r <= RX_IDLE;
                        if (rx_sync_r) byte_valid_r <= 1'b1;
                        else           frame_err_r  <= 1'b1;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_W'(1);
                    end
                end
                default: rx_state_r <= RX_IDLE;
            endcase
        end
    end

    // Loader FSM with registered memory-port and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            imem_we      <= 1'b0;
            imem_addr    <= {ADDR_W{1'b0}};
            imem_wdata   <= 32'h0000_0000;
            cpu_hold     <= 1'b1;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            byte_idx_r   <= 2'd0;
            words_left_r <= 8'd0;
`ifdef BOOT_CHECKSUM_EN
            csum_r       <= 8'h00;
`endif
        end else begin
            imem_we <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (boot_en) begin
                        state_r <= GET_COUNT;
                    end else begin
                        state_r   <= DONE;
                        cpu_hold  <= 1'b0;
                        load_done <= 1'b1;
                    end
                end
                GET_COUNT: begin
                    if (frame_err_r) begin
                        load_err  <= 1'b1;
                        imem_addr <= {ADDR_W{1'b0}};
                    end else if (byte_valid_r) begin
                        if (rx_shift_r == 8'd0) begin
                            state_r   <= DONE;
                            cpu_hold  <= 1'b0;
                            load_done <= 1'b1;
                            load_err  <= 1'b0;
                        end else if (count_too_big_s) begin
                            load_err <= 1'b1;
                        end else begin
                            words_left_r <= rx_shift_r;
                            byte_idx_r   <= 2'd0;
                            imem_addr    <= {ADDR_W{1'b0}};
`ifdef BOOT_CHECKSUM_EN
                            csum_r       <= 8'h00;
`endif
                            state_r      <= GET_DATA;
                        end
                    end else begin
                        state_r <= GET_COUNT;
                    end
                end
                GET_DATA: begin
                    if (frame_err_r) begin
                        load_err   <= 1'b1;
                        imem_addr  <= {ADDR_W{1'b0}};
                        byte_idx_r <= 2'd0;
                        state_r    <= GET_COUNT;
                    end else if (byte_valid_r) begin
                        case (byte_idx_r)
                            2'd0:    imem_wdata[7:0]   <= rx_shift_r;
                            2'd1:    imem_wdata[15:8]  <= rx_shift_r;
                            2'd2:    imem_wdata[23:16] <= rx_shift_r;
                            default: imem_wdata[31:24] <= rx_shift_r;
                        endcase
`ifdef BOOT_CHECKSUM_EN
                        csum_r <= csum_r ^ rx_shift_r;
`endif
                        byte_idx_r <= byte_idx_r + 2'd1;
                        if (byte_idx_r == 2'd3) begin
                            imem_we <= 1'b1;
                            state_r <= WRITE;
                        end
                    end else begin
                        state_r <= GET_DATA;
                    end
                end
                WRITE: begin
                    // Address advances after the strobe; after the last word it may wrap unused.
                    imem_addr    <= imem_addr + ADDR_W'(1);
                    words_left_r <= words_left_r - 8'd1;
                    if (words_left_r == 8'd1) begin
`ifdef BOOT_CHECKSUM_EN
                        state_r   <= CHECK;
`else
                        state_r   <= DONE;
                        cpu_hold  <= 1'b0;
                        load_done <= 1'b1;
                        load_err  <= 1'b0;
`endif
                    end else begin
                        state_r <= GET_DATA;
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                CHECK: begin
                    if (frame_err_r) begin
                        load_err  <= 1'b1;
                        imem_addr <= {ADDR_W{1'b0}};
                        state_r   <= GET_COUNT;
                    end else if (byte_valid_r) begin
                        if (rx_shift_r == csum_r) begin
                            state_r   <= DONE;
                            cpu_hold  <= 1'b0;
                            load_done <= 1'b1;
                            load_err  <= 1'b0;
                        end else begin
                            load_err  <= 1'b1;
                            imem_addr <= {ADDR_W{1'b0}};
                            state_r   <= GET_COUNT;
                        end
                    end else begin
                        state_r <= CHECK;
                    end
                end
`endif
                DONE: begin
                    state_r <= DONE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: vector table of image loads plus hand-written corner sequences.
module tb_uart_boot_loader;

    localparam int CPB    = 4;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              boot_en;
    logic              rx;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;

    uart_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .boot_en(boot_en), .rx(rx),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    typedef struct {
        logic [7:0]       count;
        logic [2:0][31:0] w;
        int               nwords;
        int               bad;
        logic             exp_done;
        logic             exp_err;
    } vec_t;

    wr_t  exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic we_prev  = 1'b0;
    logic [7:0] csum;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the next expected {addr,data} and last one cycle.
    always @(negedge clk) begin
        if (!reset && imem_we) begin
            check("we_single_cycle", 32'(we_prev), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", 32'(imem_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", 32'(imem_addr), 32'(e.a));
                check("write_data", imem_wdata, e.d);
            end
        end
        we_prev <= imem_we;
    end

    task automatic do_reset(input logic be);
        rx      = 1'b1;
        boot_en = be;
        reset   = 1'b1;
        repeat (3) @(negedge clk);
        reset   = 1'b0;
        csum    = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int idx);
        wr_t e;
        e.a = ADDR_W'(idx);
        e.d = w;
        exp_q.push_back(e);
        for (int b = 0; b < 4; b++) begin
            csum = csum ^ w[8*b +: 8];
            send_byte(w[8*b +: 8], 1'b1);
        end
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic [ADDR_W-1:0] a);
        check({tag, "_load_done"}, 32'(load_done), 32'(d));
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!d));
        check({tag, "_load_err"}, 32'(load_err), 32'(e));
        check({tag, "_imem_addr"}, 32'(imem_addr), 32'(a));
        check({tag, "_writes_pending"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    vec_t vecs[6];

    initial begin
        logic stop_all;
        logic [7:0] bt;
        int k;

        vecs[0] = '{8'h02, {32'h0, 32'h0010_0593, 32'h0050_0513}, 2, -1, 1'b1, 1'b0};
        vecs[1] = '{8'h41, {32'h0, 32'h0, 32'h0},                  0, -1, 1'b0, 1'b1};
        vecs[2] = '{8'h01, {32'h0, 32'h0, 32'h0000_006F},          1, -1, 1'b1, 1'b0};
        vecs[3] = '{8'h02, {32'h0, 32'h0010_0593, 32'h0050_0513}, 2,  2, 1'b0, 1'b1};
        vecs[4] = '{8'h00, {32'h0, 32'h0, 32'h0},                  0, -1, 1'b1, 1'b0};
        vecs[5] = '{8'h03, {32'hA5A5_5A5A, 32'h1234_5678, 32'hDEAD_BEEF}, 3, -1, 1'b1, 1'b0};

        // Table-driven image loads, each from a fresh reset.
        for (int v = 0; v < 6; v++) begin
            do_reset(1'b1);
            repeat (2) @(negedge clk);
            send_byte(vecs[v].count, 1'b1);
            stop_all = 1'b0;
            for (int i = 0; i < vecs[v].nwords; i++) begin
                if (!stop_all) begin
                    if (vecs[v].bad < 0 || vecs[v].bad >= 4*i + 4) begin
                        wr_t e;
                        e.a = ADDR_W'(i);
                        e.d = vecs[v].w[i];
                        exp_q.push_back(e);
                    end
                    for (int b = 0; b < 4; b++) begin
                        k = 4*i + b;
                        if (!stop_all) begin
                            bt   = vecs[v].w[i][8*b +: 8];
                            csum = csum ^ bt;
                            send_byte(bt, k != vecs[v].bad);
                            if (k == vecs[v].bad) stop_all = 1'b1;
                        end
                    end
                end
            end
`ifdef BOOT_CHECKSUM_EN
            if (vecs[v].nwords > 0 && vecs[v].bad < 0) send_byte(csum, 1'b1);
`endif
            repeat (12) @(negedge clk);
            check_status($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_err,
                         vecs[v].exp_done ? ADDR_W'(vecs[v].count) : ADDR_W'(0));
        end

        // boot_en=0: reset values in the IDLE cycle, released on the next one; later bytes ignored.
        do_reset(1'b0);
        check("bypass_idle_done", 32'(load_done), 32'd0);
        check("bypass_idle_hold", 32'(cpu_hold), 32'd1);
        @(negedge clk);
        check_status("bypass", 1'b1, 1'b0, ADDR_W'(0));
        boot_en = 1'b1;
        send_byte(8'h01, 1'b1);
        send_word(32'h0000_0013, 0);
        exp_q.delete();
        repeat (12) @(negedge clk);
        check_status("bypass_ignore", 1'b1, 1'b0, ADDR_W'(0));

        // One-clock glitch on rx must not produce a byte.
        do_reset(1'b1);
        repeat (4) @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check_status("glitch", 1'b0, 1'b0, ADDR_W'(0));
        send_byte(8'h01, 1'b1);
        csum = 8'h00;
        send_word(32'h0000_006F, 0);
`ifdef BOOT_CHECKSUM_EN
        send_byte(csum, 1'b1);
`endif
        repeat (12) @(negedge clk);
        check_status("glitch_load", 1'b1, 1'b0, ADDR_W'(1));

        // Oversize count, then a good image without reset clears the error.
        do_reset(1'b1);
        send_byte(8'h41, 1'b1);
        repeat (12) @(negedge clk);
        check_status("oversize", 1'b0, 1'b1, ADDR_W'(0));
        send_byte(8'h01, 1'b1);
        csum = 8'h00;
        send_word(32'h0000_006F, 0);
`ifdef BOOT_CHECKSUM_EN
        send_byte(csum, 1'b1);
`endif
        repeat (12) @(negedge clk);
        check_status("reload", 1'b1, 1'b0, ADDR_W'(1));

        // Reset in the middle of the second word restores every output.
        do_reset(1'b1);
        send_byte(8'h02, 1'b1);
        send_word(32'hCAFE_F00D, 0);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_we", 32'(imem_we), 32'd0);
        check("midreset_wdata", imem_wdata, 32'h0);
        check_status("midreset", 1'b0, 1'b0, ADDR_W'(0));
        reset = 1'b0;

        // Maximum image of 2**ADDR_W words; address wraps to 0 after the last write.
        do_reset(1'b1);
        send_byte(8'h40, 1'b1);
        for (int i = 0; i < 64; i++) send_word({8'(i), 8'hA5, 8'(~i), 8'(i + 3)}, i);
`ifdef BOOT_CHECKSUM_EN
        send_byte(csum, 1'b1);
`endif
        repeat (12) @(negedge clk);
        check_status("max_image", 1'b1, 1'b0, ADDR_W'(0));

`ifdef BOOT_CHECKSUM_EN
        // Checksum mismatch keeps the core held and demands a reload.
        do_reset(1'b1);
        send_byte(8'h01, 1'b1);
        send_word(32'h0000_0013, 0);
        send_byte(8'h12, 1'b1);
        repeat (12) @(negedge clk);
        check_status("csum_bad", 1'b0, 1'b1, ADDR_W'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
